// File: rtl/wb_data_memory.sv
// Pipelined Wishbone word memory with byte enables, fixed response latency and an
// in-order response queue; out-of-range accesses answer with err.
module wb_data_memory #(
    parameter int unsigned MEM_SIZE_BYTES = 32'h00001000,
    parameter int unsigned LATENCY        = 1,
    parameter int unsigned QUEUE_DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    input  logic [3:0]  wb_sel_i,
    output logic        wb_stall_o,
    output logic        wb_ack_o,
    output logic [31:0] wb_dat_o,
    output logic        wb_err_o
);
    localparam int unsigned WORDS = MEM_SIZE_BYTES / 4;
    localparam int unsigned IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int unsigned AGE_W = $clog2(LATENCY + 1);
    localparam int unsigned PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(QUEUE_DEPTH + 1);
    localparam logic [31:0] ERR_WORD = 32'hDEADBEEF;

    typedef struct packed {
        logic             err;
        logic [31:0]      data;
        logic [AGE_W-1:0] age;
    } entry_t;

    logic [31:0]      mem [WORDS];
    entry_t           q   [QUEUE_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    logic             accept;
    logic             in_range;
    logic [IDX_W-1:0] word_idx;
    logic             head_ready;
    entry_t           new_entry;

    assign wb_stall_o = (count == CNT_W'(QUEUE_DEPTH));
    assign accept     = ~rst & wb_cyc_i & wb_stb_i & ~wb_stall_o;
    assign in_range   = (wb_adr_i < 32'(MEM_SIZE_BYTES));
    assign word_idx   = wb_adr_i[IDX_W+1:2];
    assign head_ready = (count != '0) && (q[rd_ptr].age == AGE_W'(LATENCY));

    // Entry captured at the accept edge; the accept edge itself counts as the first age tick.
    always_comb begin
        new_entry.err  = ~in_range;
        new_entry.age  = AGE_W'(1);
        new_entry.data = 32'h0;
        if (!in_range) begin
            new_entry.data = ERR_WORD;
        end else if (!wb_we_i) begin
            new_entry.data = mem[word_idx];
        end
    end

    // Storage is never reset; only accepted in-range writes modify it.
    always_ff @(posedge clk) begin
        if (accept && wb_we_i && in_range) begin
            for (int b = 0; b < 4; b++) begin
                if (wb_sel_i[b]) begin
                    mem[word_idx][8*b +: 8] <= wb_dat_i[8*b +: 8];
                end
            end
        end
    end

    // Ages saturate at LATENCY; a push overrides the slot it lands in.
    always_ff @(posedge clk) begin
        for (int i = 0; i < QUEUE_DEPTH; i++) begin
            if (q[i].age != AGE_W'(LATENCY)) begin
                q[i].age <= q[i].age + AGE_W'(1);
            end
        end
        if (accept) begin
            q[wr_ptr] <= new_entry;
        end
    end

    // Queue bookkeeping; dropping cyc discards everything still pending.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (!wb_cyc_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (accept) begin
                wr_ptr <= (wr_ptr == PTR_W'(QUEUE_DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
            end
            if (head_ready) begin
                rd_ptr <= (rd_ptr == PTR_W'(QUEUE_DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(accept) - CNT_W'(head_ready);
        end
    end

    // Response outputs are a pure decode of queue state, so reset clears them at once.
    always_comb begin
        wb_ack_o = 1'b0;
        wb_err_o = 1'b0;
        wb_dat_o = 32'h0;
        if (head_ready) begin
            wb_ack_o = ~q[rd_ptr].err;
            wb_err_o = q[rd_ptr].err;
            wb_dat_o = q[rd_ptr].data;
        end
    end
endmodule

// File: tb/tb_wb_data_memory.sv
// Bench for wb_data_memory: three instances (LATENCY 1/3/4), one active at a time via its cyc.
module tb_wb_data_memory;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  cyc = 3'b000;
    logic        stb = 1'b0;
    logic        we  = 1'b0;
    logic [31:0] adr = 32'h0;
    logic [31:0] dat = 32'h0;
    logic [3:0]  sel = 4'h0;
    logic [2:0]  stall, ack, err;
    logic [31:0] dout [3];

    always #5 clk = ~clk;

    wb_data_memory #(.MEM_SIZE_BYTES(32'h1000), .LATENCY(1), .QUEUE_DEPTH(4)) u_l1 (
        .clk(clk), .rst(rst), .wb_cyc_i(cyc[0]), .wb_stb_i(stb), .wb_we_i(we),
        .wb_adr_i(adr), .wb_dat_i(dat), .wb_sel_i(sel), .wb_stall_o(stall[0]),
        .wb_ack_o(ack[0]), .wb_dat_o(dout[0]), .wb_err_o(err[0]));
    wb_data_memory #(.MEM_SIZE_BYTES(32'h1000), .LATENCY(3), .QUEUE_DEPTH(4)) u_l3 (
        .clk(clk), .rst(rst), .wb_cyc_i(cyc[1]), .wb_stb_i(stb), .wb_we_i(we),
        .wb_adr_i(adr), .wb_dat_i(dat), .wb_sel_i(sel), .wb_stall_o(stall[1]),
        .wb_ack_o(ack[1]), .wb_dat_o(dout[1]), .wb_err_o(err[1]));
    wb_data_memory #(.MEM_SIZE_BYTES(32'h1000), .LATENCY(4), .QUEUE_DEPTH(4)) u_l4 (
        .clk(clk), .rst(rst), .wb_cyc_i(cyc[2]), .wb_stb_i(stb), .wb_we_i(we),
        .wb_adr_i(adr), .wb_dat_i(dat), .wb_sel_i(sel), .wb_stall_o(stall[2]),
        .wb_ack_o(ack[2]), .wb_dat_o(dout[2]), .wb_err_o(err[2]));

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic        exp_err;
        logic [31:0] exp_dat;
    } vec_t;

    typedef struct {
        logic        err;
        logic [31:0] dat;
        int          due;
    } exp_t;

    exp_t        sbq [$];
    vec_t        vt  [14];
    logic [31:0] mm  [3][1024];
    int          lat_of [3] = '{1, 3, 4};
    int          n_cmp = 0;
    int          n_fail = 0;
    int          cyc_cnt = 0;
    int          act = 0;
    int          stall_cycles = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h required %h (cycle %0d)", name, got, want, cyc_cnt);
        end
    endtask

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // Response monitor for the active instance.
    always @(negedge clk) begin
        if (!rst) begin
            if (ack[act] || err[act]) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_resp", 32'(1), 32'(0));
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    chk("resp_kind", {30'h0, ack[act], err[act]}, {30'h0, ~e.err, e.err});
                    chk("resp_dat", dout[act], e.dat);
                    chk("resp_cycle", 32'(cyc_cnt), 32'(e.due));
                end
            end else begin
                chk("idle_dat", dout[act], 32'h0);
                if (sbq.size() > 0 && sbq[0].due < cyc_cnt) begin
                    chk("missing_resp", 32'(0), 32'(1));
                    void'(sbq.pop_front());
                end
            end
        end
    end

    task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, input logic use_exp, input logic e_err,
                         input logic [31:0] e_dat, input logic now);
        exp_t       e;
        logic [9:0] idx;
        int         guard;
        if (!now) begin
            @(negedge clk); #1;
        end
        stb = 1'b1; we = w; adr = a; dat = d; sel = s;
        guard = 0;
        while (stall[act] && guard < 50) begin
            stall_cycles++;
            @(negedge clk); #1;
            guard++;
        end
        if (guard >= 50) begin
            chk("stall_timeout", 32'(1), 32'(0));
            stb = 1'b0;
            return;
        end
        idx   = a[11:2];
        e.err = (a >= 32'h1000);
        e.dat = 32'h0;
        if (e.err) begin
            e.dat = 32'hDEADBEEF;
        end else if (w) begin
            for (int b = 0; b < 4; b++)
                if (s[b]) mm[act][idx][8*b +: 8] = d[8*b +: 8];
        end else begin
            e.dat = mm[act][idx];
        end
        if (use_exp) begin
            e.err = e_err;
            e.dat = e_dat;
        end
        e.due = cyc_cnt + lat_of[act];
        sbq.push_back(e);
        @(posedge clk);
    endtask

    task automatic idle();
        @(negedge clk); #1;
        stb = 1'b0;
    endtask

    task automatic drain();
        int g;
        g = 0;
        while (sbq.size() > 0 && g < 60) begin
            @(negedge clk); #1;
            g++;
        end
        if (sbq.size() > 0) begin
            chk("drain_timeout", 32'(sbq.size()), 32'(0));
            sbq.delete();
        end
    endtask

    task automatic chk_quiet(input string name);
        for (int i = 0; i < 3; i++) begin
            chk({name, "_stall"}, {31'h0, stall[i]}, 32'h0);
            chk({name, "_ack"}, {31'h0, ack[i]}, 32'h0);
            chk({name, "_err"}, {31'h0, err[i]}, 32'h0);
            chk({name, "_dat"}, dout[i], 32'h0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running required finished");
        $fatal(1, "timeout");
    end

    initial begin
        vt[0]  = '{1'b1, 32'h10,       32'hA5A51234, 4'hF, 1'b0, 32'h0};
        vt[1]  = '{1'b0, 32'h10,       32'h0,        4'hF, 1'b0, 32'hA5A51234};
        vt[2]  = '{1'b1, 32'h20,       32'hFFFFFFFF, 4'hF, 1'b0, 32'h0};
        vt[3]  = '{1'b1, 32'h20,       32'h00000000, 4'h5, 1'b0, 32'h0};
        vt[4]  = '{1'b0, 32'h20,       32'h0,        4'hF, 1'b0, 32'hFF00FF00};
        vt[5]  = '{1'b0, 32'h1000,     32'h0,        4'hF, 1'b1, 32'hDEADBEEF};
        vt[6]  = '{1'b0, 32'h10,       32'h0,        4'hF, 1'b0, 32'hA5A51234};
        vt[7]  = '{1'b1, 32'h1000,     32'h12345678, 4'hF, 1'b1, 32'hDEADBEEF};
        vt[8]  = '{1'b0, 32'h23,       32'h0,        4'h0, 1'b0, 32'hFF00FF00};
        vt[9]  = '{1'b1, 32'h10,       32'h00009900, 4'h2, 1'b0, 32'h0};
        vt[10] = '{1'b0, 32'h11,       32'h0,        4'h0, 1'b0, 32'hA5A59934};
        vt[11] = '{1'b1, 32'hFFC,      32'h11223344, 4'hF, 1'b0, 32'h0};
        vt[12] = '{1'b0, 32'hFFC,      32'h0,        4'hF, 1'b0, 32'h11223344};
        vt[13] = '{1'b0, 32'hFFFFFFFC, 32'h0,        4'hF, 1'b1, 32'hDEADBEEF};

        repeat (3) @(negedge clk);
        chk_quiet("reset");
        #1 rst = 1'b0;

        // LATENCY=1: table vectors back to back.
        act = 0; cyc = 3'b001;
        foreach (vt[i])
            issue(vt[i].we, vt[i].adr, vt[i].dat, vt[i].sel, 1'b1, vt[i].exp_err, vt[i].exp_dat, 1'b0);
        idle(); drain();

        // LATENCY=3: six back-to-back reads never stall.
        act = 1; cyc = 3'b010;
        for (int i = 0; i < 6; i++)
            issue(1'b1, 32'(4 * i), 32'h1111_0000 + 32'(i * 32'h0101), 4'hF, 1'b0, 1'b0, 32'h0, 1'b0);
        idle(); drain();
        stall_cycles = 0;
        for (int i = 0; i < 6; i++)
            issue(1'b0, 32'(4 * i), 32'h0, 4'hF, 1'b0, 1'b0, 32'h0, 1'b0);
        idle(); drain();
        chk("l3_stall_cycles", 32'(stall_cycles), 32'(0));

        // LATENCY=4: five reads fill the queue and stall until the first pop.
        act = 2; cyc = 3'b100;
        for (int i = 0; i < 4; i++)
            issue(1'b1, 32'(4 * i), 32'h2222_0000 + 32'(i), 4'hF, 1'b0, 1'b0, 32'h0, 1'b0);
        issue(1'b1, 32'h10, 32'hCAFEF00D, 4'hF, 1'b0, 1'b0, 32'h0, 1'b0);
        idle(); drain();
        stall_cycles = 0;
        for (int i = 0; i < 5; i++)
            issue(1'b0, 32'(4 * i), 32'h0, 4'hF, 1'b0, 1'b0, 32'h0, 1'b0);
        idle(); drain();
        chk("l4_stall_cycles", 32'(stall_cycles), 32'(1));

        // Abort three pending reads by dropping cyc for one cycle.
        for (int i = 0; i < 3; i++)
            issue(1'b0, 32'(4 * i), 32'h0, 4'hF, 1'b0, 1'b0, 32'h0, 1'b0);
        @(negedge clk); #1;
        stb = 1'b0; cyc = 3'b000; sbq.delete();
        @(negedge clk); #1;
        cyc = 3'b100;
        repeat (6) @(negedge clk);
        #1 chk("abort_cyc_stall", {31'h0, stall[2]}, 32'h0);
        issue(1'b0, 32'h10, 32'h0, 4'hF, 1'b1, 1'b0, 32'hCAFEF00D, 1'b0);
        idle(); drain();

        // Abort three pending reads with a one-cycle reset pulse.
        for (int i = 0; i < 3; i++)
            issue(1'b0, 32'(4 * i), 32'h0, 4'hF, 1'b0, 1'b0, 32'h0, 1'b0);
        @(negedge clk); #1;
        stb = 1'b0; rst = 1'b1; sbq.delete();
        #1 chk_quiet("rst_pulse");
        @(negedge clk); #1;
        rst = 1'b0;
        issue(1'b0, 32'h10, 32'h0, 4'hF, 1'b1, 1'b0, 32'hCAFEF00D, 1'b1);
        idle(); drain();
        repeat (6) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
